// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_t;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int unsigned cpb(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always on rd_data.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // Data is meaningless while empty; hold it at zero so reset leaves a clean output.
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    // A write into a full FIFO is allowed when a pop frees the head in the same cycle.
    always_comb begin
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array; no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with glitch-rejecting start detection, FWFT receive FIFO and
// sticky framing/overrun flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_en,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int unsigned CPB   = cpb(CLK_HZ, BAUD);
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

    logic                      sync_q, rx_s;
    rx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      push, fe_set, ov_set;
    logic                      fifo_full, fifo_empty;

    // Two-flop synchroniser; idle-high reset value so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= rxd;
            rx_s   <= sync_q;
        end
    end

    // Receive FSM: baud counter, bit index and shift register next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        fe_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = CNT_W'(HALF - 1);
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = CNT_W'(CPB - 1);
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
                    cnt_d   = CNT_W'(CPB - 1);
                    if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StBreak: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky flags: a new error event wins over a simultaneous clear.
    always_comb begin
        ov_set      = push && fifo_full && !rd_en;
        frame_err_d = fe_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
        overrun_d   = ov_set ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
    end

    // FSM and flag state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (shreg_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (level)
    );

    assign rd_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench: a fast-baud instance carries the functional and random tests against a
// frame-level queue model; a default-parameter instance pins the absolute latency.
module tb_uart_rx_fifo;

    // Small instance: (1_000_000 + 30_000) / 60_000 = 17 clocks per bit, half = 8.
    localparam int CPB_S    = 17;
    localparam int HALF_S   = 8;
    // Default instance: 868 clocks per bit.
    localparam int CPB_B    = 868;
    // Clock edges from the pin falling (just after edge k) to the FIFO write edge.
    localparam int PUSH_OFS = 3 + HALF_S + 9 * CPB_S;

    typedef struct {
        int unsigned at;
        logic [7:0]  data;
        bit          ok;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rxd_b = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic       rd_en_b = 1'b0;
    logic       err_clr_b = 1'b0;
    logic [7:0] rd_data, rd_data_b;
    logic       rd_valid, rd_valid_b;
    logic [4:0] level, level_b;
    logic       frame_err, frame_err_b, overrun, overrun_b;

    bit          rd_manual = 1'b0, clr_manual = 1'b0, rand_on = 1'b0, abort = 1'b0;
    bit          chk_on = 1'b0;
    int unsigned cyc = 0;
    int          n_vec = 0, n_fail = 0;
    ev_t         sched[$];
    logic [7:0]  mq[$];
    bit          fe_m = 1'b0, ov_m = 1'b0;
    logic [7:0]  pat [4] = '{8'h55, 8'hA3, 8'h00, 8'hFF};

    uart_rx_fifo #(
        .CLK_HZ     (1_000_000),
        .BAUD       (60_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_en     (rd_en),
        .level     (level),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    uart_rx_fifo dut_b (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd_b),
        .rd_data   (rd_data_b),
        .rd_valid  (rd_valid_b),
        .rd_en     (rd_en_b),
        .level     (level_b),
        .frame_err (frame_err_b),
        .overrun   (overrun_b),
        .err_clr   (err_clr_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: each frame lands at a fixed edge after its start; pops and
    // pushes follow the FIFO/flag rules directly.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mq.delete();
            sched.delete();
            fe_m = 1'b0;
            ov_m = 1'b0;
        end else begin
            bit  pop, have_ev, fe_s, ov_s;
            ev_t e;
            cyc++;
            pop     = rd_en && (mq.size() != 0);
            have_ev = (sched.size() != 0) && (sched[0].at == cyc);
            fe_s    = 1'b0;
            ov_s    = 1'b0;
            if (have_ev) e = sched.pop_front();
            if (have_ev && !e.ok) fe_s = 1'b1;
            if (have_ev && e.ok && mq.size() == 16 && !pop) ov_s = 1'b1;
            if (pop) void'(mq.pop_front());
            if (have_ev && e.ok && !ov_s) mq.push_back(e.data);
            fe_m = fe_s ? 1'b1 : (err_clr ? 1'b0 : fe_m);
            ov_m = ov_s ? 1'b1 : (err_clr ? 1'b0 : ov_m);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_on && !reset) begin
            chk("rd_valid", int'(rd_valid), int'(mq.size() != 0));
            chk("level", int'(level), mq.size());
            chk("frame_err", int'(frame_err), int'(fe_m));
            chk("overrun", int'(overrun), int'(ov_m));
            if (mq.size() != 0) chk("rd_data", int'(rd_data), int'(mq[0]));
        end
    end

    // Read/clear strobes: manual pulses from the main sequence plus optional random traffic.
    initial forever begin
        @(posedge clk);
        #2;
        rd_en   = rd_manual | (rand_on & ($urandom_range(0, 2) == 0));
        err_clr = clr_manual | (rand_on & ($urandom_range(0, 15) == 0));
    end

    task automatic drive(input bit big, input bit v, input int n);
        if (abort) return;
        if (big) rxd_b = v;
        else rxd = v;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (abort) begin
                rxd = 1'b1;
                return;
            end
        end
    endtask

    // Called #1 after an edge; the start bit begins immediately.
    task automatic send(input bit big, input logic [7:0] b, input int stop_len,
                        input bit stop_ok, input int gap);
        ev_t e;
        int  n;
        n = big ? CPB_B : CPB_S;
        if (!big) begin
            e.at   = cyc + PUSH_OFS;
            e.data = b;
            e.ok   = stop_ok;
            sched.push_back(e);
        end
        drive(big, 1'b0, n);
        for (int i = 0; i < 8; i++) drive(big, b[i], n);
        drive(big, stop_ok, stop_len);
        drive(big, 1'b1, gap);
    endtask

    task automatic pop_one();
        rd_manual = 1'b1;
        @(posedge clk);
        #1;
        rd_manual = 1'b0;
    endtask

    task automatic clear_flags();
        clr_manual = 1'b1;
        @(posedge clk);
        #1;
        clr_manual = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_b_rd_valid", int'(rd_valid_b), 0);
        chk("rst_b_level", int'(level_b), 0);
        reset  = 1'b0;
        chk_on = 1'b1;
        @(posedge clk);
        #1;

        // Default parameters: write edge is 3 + 434 + 9*868 = 8249 edges after the pin falls.
        fork
            send(1'b1, 8'hA5, CPB_B, 1'b1, 4);
            begin
                repeat (8248) @(posedge clk);
                #1;
                chk("lat_before_push", int'(rd_valid_b), 0);
                @(posedge clk);
                #1;
                chk("lat_rd_valid", int'(rd_valid_b), 1);
                chk("lat_rd_data", int'(rd_data_b), 8'hA5);
                chk("lat_level", int'(level_b), 1);
            end
        join

        // Four frames queued, then drained in order.
        for (int i = 0; i < 4; i++) send(1'b0, pat[i], CPB_S, 1'b1, 4);
        chk("peak_level", int'(level), 4);
        chk("flags_clean", int'(frame_err) + int'(overrun), 0);
        for (int i = 0; i < 4; i++) begin
            chk("pop_order", int'(rd_data), int'(pat[i]));
            pop_one();
        end
        chk("drained", int'(level), 0);

        // Short glitch, then a frame whose start falls on the first cycle back in idle.
        drive(1'b0, 1'b0, 5);
        drive(1'b0, 1'b1, 4);
        send(1'b0, 8'h5A, CPB_S, 1'b1, 4);
        chk("glitch_level", int'(level), 1);
        chk("glitch_next_frame", int'(rd_data), 8'h5A);
        pop_one();

        // Stop bit held low for three bit times.
        send(1'b0, 8'h3C, 3 * CPB_S, 1'b0, 2 * CPB_S);
        chk("break_frame_err", int'(frame_err), 1);
        chk("break_level", int'(level), 0);
        send(1'b0, 8'h12, CPB_S, 1'b1, 4);
        chk("after_break_data", int'(rd_data), 8'h12);
        chk("after_break_level", int'(level), 1);
        clear_flags();
        chk("err_clr", int'(frame_err), 0);
        pop_one();

        // Seventeen back-to-back frames without pops.
        for (int i = 0; i < 17; i++) begin
            send(1'b0, 8'(i * 13 + 5),
                 (i == 16) ? CPB_S : ((i == 3) ? HALF_S + 1 : $urandom_range(HALF_S + 1, CPB_S)),
                 1'b1, (i == 16) ? 4 : 0);
        end
        chk("full_level", int'(level), 16);
        chk("full_overrun", int'(overrun), 1);
        chk("full_head", int'(rd_data), 5);
        repeat (16) pop_one();
        clear_flags();
        chk("overrun_cleared", int'(overrun), 0);

        // Same again, with a pop on the 17th stop-sample cycle.
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 8'(i * 13 + 5), $urandom_range(HALF_S + 1, CPB_S), 1'b1, 0);
        end
        fork
            send(1'b0, 8'(16 * 13 + 5), CPB_S, 1'b1, 4);
            begin
                repeat (PUSH_OFS - 1) @(posedge clk);
                #1;
                rd_manual = 1'b1;
                @(posedge clk);
                #1;
                rd_manual = 1'b0;
            end
        join
        chk("pushpop_level", int'(level), 16);
        chk("pushpop_overrun", int'(overrun), 0);
        chk("pushpop_head", int'(rd_data), 18);
        repeat (16) pop_one();

        // Reset in the middle of a frame with data and a flag pending.
        send(1'b0, 8'hF0, CPB_S, 1'b0, 2 * CPB_S);
        send(1'b0, 8'h11, CPB_S, 1'b1, 4);
        send(1'b0, 8'h22, CPB_S, 1'b1, 4);
        fork
            send(1'b0, 8'h81, CPB_S, 1'b1, 4);
            begin
                repeat (4 * CPB_S) @(posedge clk);
                #3;
                reset = 1'b1;
                abort = 1'b1;
                #1;
                chk("mid_rst_rd_valid", int'(rd_valid), 0);
                chk("mid_rst_rd_data", int'(rd_data), 0);
                chk("mid_rst_level", int'(level), 0);
                chk("mid_rst_frame_err", int'(frame_err), 0);
                chk("mid_rst_b_rd_valid", int'(rd_valid_b), 0);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, 8'h7E, CPB_S, 1'b1, 4);
        chk("post_rst_level", int'(level), 1);
        chk("post_rst_data", int'(rd_data), 8'h7E);
        pop_one();

        // Random frames, gaps, stop lengths, bad stops, pops and clears.
        rand_on = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                send(1'b0, 8'($urandom), CPB_S, 1'b0, $urandom_range(2, 5));
            end else begin
                send(1'b0, 8'($urandom), $urandom_range(HALF_S + 1, CPB_S), 1'b1,
                     $urandom_range(0, 3));
            end
        end
        repeat (2 * CPB_S) @(posedge clk);
        #1;
        rand_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
